// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: integer ALU, branch target adder and EX/MEM pipeline register
module execute_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pcDE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [2:0]       AluControlE,
  input  logic [WIDTH-1:0] SignImmE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [REGW-1:0]  WriteRegE,
  output logic [WIDTH-1:0] ALUResultE,
  output logic             ZeroE,
  output logic [WIDTH-1:0] ALUOutM,
  output logic             ZeroM,
  output logic [WIDTH-1:0] BranchTargetM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [REGW-1:0]  WriteRegM,
  output logic [WIDTH-1:0] pcEM
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] w_alu_result;
  logic [WIDTH-1:0] w_target;
  logic [4:0]       w_shamt;
  logic             w_lt;

  logic [WIDTH-1:0] r_alu_out;
  logic             r_zero;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_write_data;
  logic [REGW-1:0]  r_write_reg;
  logic [WIDTH-1:0] r_pc;

  // Shifts only ever look at the low five bits of operand B.
  assign w_shamt = SrcBE[4:0];
  assign w_lt    = $signed(SrcAE) < $signed(SrcBE);

  // Combinational ALU; every control code is defined so there is no default-X path.
  always_comb begin
    w_alu_result = '0;
    case (AluControlE)
      OP_AND: w_alu_result = SrcAE & SrcBE;
      OP_OR:  w_alu_result = SrcAE | SrcBE;
      OP_ADD: w_alu_result = SrcAE + SrcBE;
      OP_XOR: w_alu_result = SrcAE ^ SrcBE;
      OP_SLL: w_alu_result = SrcAE << w_shamt;
      OP_SRL: w_alu_result = SrcAE >> w_shamt;
      OP_SUB: w_alu_result = SrcAE - SrcBE;
      OP_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_alu_result = '0;
    endcase
  end

  // Branch/jump target is a separate adder so it never depends on the ALU op.
  assign w_target = pcDE + SignImmE;

  assign ALUResultE = w_alu_result;
  assign ZeroE      = (w_alu_result == '0);

  // EX/MEM register: loads every cycle, async clear drops any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alu_out    <= '0;
      r_zero       <= 1'b0;
      r_target     <= '0;
      r_write_data <= '0;
      r_write_reg  <= '0;
      r_pc         <= '0;
    end else begin
      r_alu_out    <= w_alu_result;
      r_zero       <= ZeroE;
      r_target     <= w_target;
      r_write_data <= WriteDataE;
      r_write_reg  <= WriteRegE;
      r_pc         <= pcDE;
    end
  end

  assign ALUOutM       = r_alu_out;
  assign ZeroM         = r_zero;
  assign BranchTargetM = r_target;
  assign WriteDataM    = r_write_data;
  assign WriteRegM     = r_write_reg;
  assign pcEM          = r_pc;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] pcDE, SrcAE, SrcBE, SignImmE, WriteDataE;
  logic [2:0]  AluControlE;
  logic [4:0]  WriteRegE;
  logic [31:0] ALUResultE, ALUOutM, BranchTargetM, WriteDataM, pcEM;
  logic        ZeroE, ZeroM;
  logic [4:0]  WriteRegM;

  execute_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .reset(rst_n), .pcDE(pcDE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .AluControlE(AluControlE), .SignImmE(SignImmE), .WriteDataE(WriteDataE),
    .WriteRegE(WriteRegE), .ALUResultE(ALUResultE), .ZeroE(ZeroE),
    .ALUOutM(ALUOutM), .ZeroM(ZeroM), .BranchTargetM(BranchTargetM),
    .WriteDataM(WriteDataM), .WriteRegM(WriteRegM), .pcEM(pcEM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] exp_alu;
    logic        exp_zero;
    logic [31:0] exp_tgt;
  } vec_t;

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] tgt;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [31:0] pc;
  } exp_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [2:0] c, logic [31:0] a, logic [31:0] b,
                              logic [31:0] pc, logic [31:0] imm,
                              logic [31:0] ea, logic ez, logic [31:0] et);
    vec_t v;
    v.ctrl = c; v.a = a; v.b = b; v.pc = pc; v.imm = imm;
    v.exp_alu = ea; v.exp_zero = ez; v.exp_tgt = et;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_m_zero(input string tag);
    chk({tag, " ALUOutM"}, ALUOutM, 32'h0);
    chk({tag, " ZeroM"}, 32'(ZeroM), 32'h0);
    chk({tag, " BranchTargetM"}, BranchTargetM, 32'h0);
    chk({tag, " WriteDataM"}, WriteDataM, 32'h0);
    chk({tag, " WriteRegM"}, 32'(WriteRegM), 32'h0);
    chk({tag, " pcEM"}, pcEM, 32'h0);
  endtask

  // Drive vector i at a falling edge, push expectation, check it one rising edge later.
  task automatic apply_vec(input int i);
    exp_t e, got;
    logic [31:0] prev_pc;
    @(negedge clk);
    prev_pc     = pcEM;
    AluControlE = vecs[i].ctrl;
    SrcAE       = vecs[i].a;
    SrcBE       = vecs[i].b;
    pcDE        = vecs[i].pc;
    SignImmE    = vecs[i].imm;
    WriteDataE  = 32'hA500_0000 + 32'(i);
    WriteRegE   = 5'(i + 1);
    e.alu = vecs[i].exp_alu; e.zero = vecs[i].exp_zero; e.tgt = vecs[i].exp_tgt;
    e.wd  = 32'hA500_0000 + 32'(i); e.wr = 5'(i + 1); e.pc = vecs[i].pc;
    sb_q.push_back(e);
    #1;
    chk($sformatf("v%0d ALUResultE", i), ALUResultE, vecs[i].exp_alu);
    chk($sformatf("v%0d ZeroE", i), 32'(ZeroE), 32'(vecs[i].exp_zero));
    chk($sformatf("v%0d pcEM held before edge", i), pcEM, prev_pc);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard empty", 32'h0, 32'h1);
    end else begin
      got = sb_q.pop_front();
      chk($sformatf("v%0d ALUOutM", i), ALUOutM, got.alu);
      chk($sformatf("v%0d ZeroM", i), 32'(ZeroM), 32'(got.zero));
      chk($sformatf("v%0d BranchTargetM", i), BranchTargetM, got.tgt);
      chk($sformatf("v%0d WriteDataM", i), WriteDataM, got.wd);
      chk($sformatf("v%0d WriteRegM", i), 32'(WriteRegM), 32'(got.wr));
      chk($sformatf("v%0d pcEM", i), pcEM, got.pc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(3'b010, 32'd5,         32'd7,         32'h0000_0100, 32'hFFFF_FFF8, 32'd12,        1'b0, 32'h0000_00F8);
    vecs[1]  = mk(3'b110, 32'h1234,      32'h1234,      32'hFFFF_FFFC, 32'd8,         32'h0,         1'b1, 32'h0000_0004);
    vecs[2]  = mk(3'b110, 32'h0,         32'h1,         32'h0000_0100, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b0, 32'h0000_00F8);
    vecs[3]  = mk(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFFF_FFFC, 32'd8,         32'h00F0_00F0, 1'b0, 32'h0000_0004);
    vecs[4]  = mk(3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_2000, 32'h0000_0010, 32'hFFF0_FFF0, 1'b0, 32'h0000_2010);
    vecs[5]  = mk(3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_2004, 32'hFFFF_FFFC, 32'hFF00_FF00, 1'b0, 32'h0000_2000);
    vecs[6]  = mk(3'b100, 32'h1,         32'h21,        32'h0000_2008, 32'h0,         32'h2,         1'b0, 32'h0000_2008);
    vecs[7]  = mk(3'b101, 32'h8000_0000, 32'd31,        32'h0000_200C, 32'h4,         32'h1,         1'b0, 32'h0000_2010);
    vecs[8]  = mk(3'b111, 32'hFFFF_FFFF, 32'h1,         32'h0000_2010, 32'h8,         32'h1,         1'b0, 32'h0000_2018);
    vecs[9]  = mk(3'b111, 32'h1,         32'hFFFF_FFFF, 32'h0000_2014, 32'h8,         32'h0,         1'b1, 32'h0000_201C);
    vecs[10] = mk(3'b111, 32'h7,         32'h7,         32'h0000_2018, 32'h8,         32'h0,         1'b1, 32'h0000_2020);
    vecs[11] = mk(3'b010, 32'hFFFF_FFFF, 32'h1,         32'h0000_201C, 32'h8,         32'h0,         1'b1, 32'h0000_2024);
    vecs[12] = mk(3'b101, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0000_2020, 32'h8,         32'h0800_0000, 1'b0, 32'h0000_2028);
    vecs[13] = mk(3'b100, 32'h0000_0003, 32'h0000_0000, 32'h0000_2024, 32'h8,         32'h0000_0003, 1'b0, 32'h0000_202C);

    rst_n       = 1'b0;
    AluControlE = 3'b010;
    SrcAE       = 32'd5;
    SrcBE       = 32'd7;
    pcDE        = 32'h0000_0100;
    SignImmE    = 32'h0000_0040;
    WriteDataE  = 32'hDEAD_BEEF;
    WriteRegE   = 5'd9;

    // Held in reset with live inputs: registered outputs stay clear, ALU stays live.
    repeat (3) @(posedge clk);
    #1;
    chk_m_zero("in reset");
    chk("ALUResultE during reset", ALUResultE, 32'd12);
    chk("ZeroE during reset", 32'(ZeroE), 32'h0);

    // First capture happens on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset ALUOutM", ALUOutM, 32'd12);
    chk("post-reset BranchTargetM", BranchTargetM, 32'h0000_0140);
    chk("post-reset WriteDataM", WriteDataM, 32'hDEAD_BEEF);
    chk("post-reset WriteRegM", 32'(WriteRegM), 32'd9);
    chk("post-reset pcEM", pcEM, 32'h0000_0100);

    // Back-to-back table vectors through the pipeline register.
    for (int i = 0; i < NV; i++) apply_vec(i);

    // Asynchronous reset between edges clears in-flight values at once.
    apply_vec(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_m_zero("async reset");
    @(posedge clk);
    #1;
    chk_m_zero("held reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply_vec(8);

    if (sb_q.size() != 0) chk("scoreboard drained", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
